// File: rtl/opcol_collector.sv
// Operand collector: captures one issued packet, reads its valid source operands
// from the register file one at a time, then presents the collected packet to execute.
module opcol_collector #(
   parameter int PKT_W       = 128,
   parameter int SM_W        = 2,
   parameter int WARP_W      = 5,
   parameter int CORE_N      = 32,
   parameter int REG_W       = 6,
   parameter int DATA_W      = 32,
   parameter int SRC_VLD_POS = 0,
   parameter int SRC_REG_POS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SM_W-1:0]     issuedSM_i,
   input  logic [WARP_W-1:0]   issuedWarp_i,
   input  logic                issuedPacketValid_i,
   input  logic [PKT_W-1:0]    issuedPacket_i,
   input  logic [CORE_N-1:0]   issuedMask_i,
   input  logic                flush_i,
   input  logic [WARP_W-1:0]   flushWarp_i,
   output logic                stall_o,
   output logic                rfReadReq_o,
   output logic [WARP_W-1:0]   rfReadWarp_o,
   output logic [REG_W-1:0]    rfReadReg_o,
   input  logic                rfReadValid_i,
   input  logic [DATA_W-1:0]   rfReadData_i,
   output logic                exValid_o,
   input  logic                exReady_i,
   output logic [SM_W-1:0]     exSM_o,
   output logic [WARP_W-1:0]   exWarp_o,
   output logic [PKT_W-1:0]    exPacket_o,
   output logic [CORE_N-1:0]   exMask_o,
   output logic [3*DATA_W-1:0] exOperand_o
);

   typedef enum logic [1:0] {IDLE, READ, DISPATCH, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [SM_W-1:0]         sm_q, sm_d;
   logic [WARP_W-1:0]       warp_q, warp_d;
   logic [PKT_W-1:0]        pkt_q, pkt_d;
   logic [CORE_N-1:0]       mask_q, mask_d;
   logic [2:0][DATA_W-1:0]  opnd_q, opnd_d;
   logic [2:0]              pend_q, pend_d;
   logic [1:0]              src_q, src_d;
   logic                    outst_q, outst_d;
   logic                    req_q, req_d;
   logic [REG_W-1:0]        rreg_q, rreg_d;
   logic [WARP_W-1:0]       rwarp_q, rwarp_d;

   logic [2:0]              in_vld;
   logic [1:0]              nxt_src;
   logic [REG_W-1:0]        nxt_reg;
   logic                    flush_hit;
   logic                    in_flushed;

   always_comb begin
      in_vld     = issuedPacket_i[SRC_VLD_POS +: 3];
      in_flushed = flush_i && (flushWarp_i == issuedWarp_i);
      flush_hit  = flush_i && (flushWarp_i == warp_q);
      nxt_src    = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
      nxt_reg    = pkt_q[SRC_REG_POS + int'(nxt_src) * REG_W +: REG_W];
   end

   always_comb begin
      state_d = state_q;
      sm_d    = sm_q;
      warp_d  = warp_q;
      pkt_d   = pkt_q;
      mask_d  = mask_q;
      opnd_d  = opnd_q;
      pend_d  = pend_q;
      src_d   = src_q;
      outst_d = outst_q;
      req_d   = 1'b0;
      rreg_d  = rreg_q;
      rwarp_d = rwarp_q;
      case (state_q)
         IDLE: begin
            if (issuedPacketValid_i && !in_flushed) begin
               sm_d    = issuedSM_i;
               warp_d  = issuedWarp_i;
               pkt_d   = issuedPacket_i;
               mask_d  = issuedMask_i;
               opnd_d  = '0;
               pend_d  = in_vld;
               state_d = (|in_vld) ? READ : DISPATCH;
            end
         end
         READ: begin
            if (flush_hit) begin
               pend_d = '0;
               // A return landing in the flush cycle retires the read, so no drain needed.
               if (outst_q && !rfReadValid_i) begin
                  state_d = DRAIN;
               end else begin
                  outst_d = 1'b0;
                  state_d = IDLE;
               end
            end else if (outst_q) begin
               if (rfReadValid_i) begin
                  opnd_d[src_q] = rfReadData_i;
                  outst_d       = 1'b0;
                  if (pend_q == 3'b000) state_d = DISPATCH;
               end
            end else if (|pend_q) begin
               req_d           = 1'b1;
               outst_d         = 1'b1;
               src_d           = nxt_src;
               rreg_d          = nxt_reg;
               rwarp_d         = warp_q;
               pend_d[nxt_src] = 1'b0;
            end else begin
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            if (exReady_i || flush_hit) state_d = IDLE;
         end
         DRAIN: begin
            if (rfReadValid_i) begin
               outst_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sm_q    <= '0;
         warp_q  <= '0;
         pkt_q   <= '0;
         mask_q  <= '0;
         opnd_q  <= '0;
         pend_q  <= '0;
         src_q   <= '0;
         outst_q <= 1'b0;
         req_q   <= 1'b0;
         rreg_q  <= '0;
         rwarp_q <= '0;
      end else begin
         state_q <= state_d;
         sm_q    <= sm_d;
         warp_q  <= warp_d;
         pkt_q   <= pkt_d;
         mask_q  <= mask_d;
         opnd_q  <= opnd_d;
         pend_q  <= pend_d;
         src_q   <= src_d;
         outst_q <= outst_d;
         req_q   <= req_d;
         rreg_q  <= rreg_d;
         rwarp_q <= rwarp_d;
      end
   end

   assign stall_o      = (state_q != IDLE);
   assign exValid_o    = (state_q == DISPATCH);
   assign rfReadReq_o  = req_q;
   assign rfReadReg_o  = rreg_q;
   assign rfReadWarp_o = rwarp_q;
   assign exSM_o       = sm_q;
   assign exWarp_o     = warp_q;
   assign exPacket_o   = pkt_q;
   assign exMask_o     = mask_q;
   assign exOperand_o  = opnd_q;

endmodule

// File: tb/tb_opcol_collector.sv
// Directed bench for opcol_collector: a latency-2 register-file model plus a
// manual return path, with scenario tasks checking outputs #1 after each clock edge.
module tb_opcol_collector;
   localparam int PKT_W = 128, SM_W = 2, WARP_W = 5, CORE_N = 32, REG_W = 6, DATA_W = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic [SM_W-1:0]     issuedSM_i;
   logic [WARP_W-1:0]   issuedWarp_i;
   logic                issuedPacketValid_i;
   logic [PKT_W-1:0]    issuedPacket_i;
   logic [CORE_N-1:0]   issuedMask_i;
   logic                flush_i;
   logic [WARP_W-1:0]   flushWarp_i;
   logic                stall_o, rfReadReq_o, rfReadValid_i, exValid_o, exReady_i;
   logic [WARP_W-1:0]   rfReadWarp_o, exWarp_o;
   logic [REG_W-1:0]    rfReadReg_o;
   logic [DATA_W-1:0]   rfReadData_i;
   logic [SM_W-1:0]     exSM_o;
   logic [PKT_W-1:0]    exPacket_o;
   logic [CORE_N-1:0]   exMask_o;
   logic [3*DATA_W-1:0] exOperand_o;

   int checks = 0;
   int errors = 0;

   // register-file model: returns two cycles after the request pulse
   logic             rf_en = 1'b1;
   logic             m1 = 1'b0, m2 = 1'b0;
   logic [REG_W-1:0] m1reg = '0, m2reg = '0;
   logic             man_vld = 1'b0;
   logic [DATA_W-1:0] man_data = '0;
   int               req_cnt = 0, ex_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      m1    <= rfReadReq_o && rf_en;
      m1reg <= rfReadReg_o;
      m2    <= m1;
      m2reg <= m1reg;
      if (rfReadReq_o) req_cnt <= req_cnt + 1;
      if (exValid_o)   ex_cnt  <= ex_cnt + 1;
   end

   assign rfReadValid_i = man_vld | m2;
   assign rfReadData_i  = man_vld ? man_data :
                          (m2reg == 6'd5) ? 32'hA :
                          (m2reg == 6'd9) ? 32'hB : 32'h100 + 32'(m2reg);

   opcol_collector dut (
      .clk(clk), .reset(reset),
      .issuedSM_i(issuedSM_i), .issuedWarp_i(issuedWarp_i),
      .issuedPacketValid_i(issuedPacketValid_i), .issuedPacket_i(issuedPacket_i),
      .issuedMask_i(issuedMask_i), .flush_i(flush_i), .flushWarp_i(flushWarp_i),
      .stall_o(stall_o), .rfReadReq_o(rfReadReq_o), .rfReadWarp_o(rfReadWarp_o),
      .rfReadReg_o(rfReadReg_o), .rfReadValid_i(rfReadValid_i), .rfReadData_i(rfReadData_i),
      .exValid_o(exValid_o), .exReady_i(exReady_i), .exSM_o(exSM_o), .exWarp_o(exWarp_o),
      .exPacket_o(exPacket_o), .exMask_o(exMask_o), .exOperand_o(exOperand_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PKT_W-1:0] mkpkt(input logic [2:0] v, input logic [5:0] r0,
                                              input logic [5:0] r1, input logic [5:0] r2,
                                              input logic [27:0] tag);
      logic [PKT_W-1:0] p;
      p          = '0;
      p[2:0]     = v;
      p[8:3]     = r0;
      p[14:9]    = r1;
      p[20:15]   = r2;
      p[127:100] = tag;
      return p;
   endfunction

   // drives a packet for exactly one capture edge
   task automatic issue(input logic [1:0] sm, input logic [4:0] warp, input logic [PKT_W-1:0] pkt,
                        input logic [31:0] mask);
      issuedSM_i          = sm;
      issuedWarp_i        = warp;
      issuedPacket_i      = pkt;
      issuedMask_i        = mask;
      issuedPacketValid_i = 1'b1;
      tick();
      issuedPacketValid_i = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({stall_o, rfReadReq_o, exValid_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000", {stall_o, rfReadReq_o, exValid_o});
      end
      checks++;
      if ({exOperand_o, exPacket_o, exWarp_o, rfReadReg_o} !== '0) begin
         errors++;
         $display("FAIL reset_data got nonzero want 0");
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_read();
      logic [PKT_W-1:0] pkt;
      logic [5:0] regs [4];
      int nreq, cyc;
      logic stall_bad, warp_bad;
      pkt = mkpkt(3'b101, 6'd5, 6'd7, 6'd9, 28'hC0FFEE1);
      issue(2'd1, 5'd3, pkt, 32'hF0F0_1234);
      nreq = 0; stall_bad = 1'b0; warp_bad = 1'b0; cyc = 0;
      while (!exValid_o && cyc < 40) begin
         if (!stall_o) stall_bad = 1'b1;
         if (rfReadReq_o) begin
            if (nreq < 4) regs[nreq] = rfReadReg_o;
            if (rfReadWarp_o !== 5'd3) warp_bad = 1'b1;
            nreq++;
         end
         tick();
         cyc++;
      end
      checks++;
      if (!exValid_o) begin errors++; $display("FAIL read_timeout exValid_o=%b want 1", exValid_o); end
      checks++;
      if (nreq != 2 || regs[0] !== 6'd5 || regs[1] !== 6'd9) begin
         errors++;
         $display("FAIL read_reqs got n=%0d r0=%0d r1=%0d want n=2 r0=5 r1=9", nreq, regs[0], regs[1]);
      end
      checks++;
      if (warp_bad || stall_bad) begin
         errors++;
         $display("FAIL read_warp_stall warp_bad=%b stall_bad=%b want 0 0", warp_bad, stall_bad);
      end
      checks++;
      if (exOperand_o !== {32'hB, 32'h0, 32'hA} || !stall_o) begin
         errors++;
         $display("FAIL read_operands got %h want %h", exOperand_o, {32'hB, 32'h0, 32'hA});
      end
      checks++;
      if (exWarp_o !== 5'd3 || exSM_o !== 2'd1 || exMask_o !== 32'hF0F0_1234 || exPacket_o !== pkt) begin
         errors++;
         $display("FAIL read_fields got w=%0d sm=%0d m=%h want w=3 sm=1 m=f0f01234", exWarp_o, exSM_o, exMask_o);
      end
      exReady_i = 1'b1;
      tick();
      exReady_i = 1'b0;
      checks++;
      if (exValid_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL read_handshake got v=%b s=%b want 0 0", exValid_o, stall_o);
      end
   endtask

   task automatic test_nosrc_stall();
      logic [PKT_W-1:0] pkt;
      int r0;
      logic stable_bad;
      pkt = mkpkt(3'b000, 6'd1, 6'd2, 6'd3, 28'h5A5A5A5);
      r0 = req_cnt;
      issue(2'd2, 5'd7, pkt, 32'h0000_00FF);
      checks++;
      if (exValid_o !== 1'b1 || stall_o !== 1'b1 || exOperand_o !== '0) begin
         errors++;
         $display("FAIL nosrc_dispatch got v=%b s=%b op=%h want 1 1 0", exValid_o, stall_o, exOperand_o);
      end
      stable_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (exValid_o !== 1'b1 || exPacket_o !== pkt || exWarp_o !== 5'd7 || exSM_o !== 2'd2
             || exMask_o !== 32'h0000_00FF) stable_bad = 1'b1;
      end
      checks++;
      if (stable_bad) begin errors++; $display("FAIL stall_stable got unstable want stable 4 cycles"); end
      exReady_i = 1'b1;
      tick();
      exReady_i = 1'b0;
      checks++;
      if (exValid_o !== 1'b0 || stall_o !== 1'b0 || req_cnt != r0) begin
         errors++;
         $display("FAIL nosrc_done got v=%b s=%b reqs=%0d want 0 0 0", exValid_o, stall_o, req_cnt - r0);
      end
   endtask

   task automatic test_flush_read();
      int e0;
      rf_en = 1'b0;
      e0 = ex_cnt;
      issue(2'd0, 5'd3, mkpkt(3'b001, 6'd5, 6'd0, 6'd0, 28'h1), 32'hFFFF_FFFF);
      tick();
      checks++;
      if (rfReadReq_o !== 1'b1 || rfReadReg_o !== 6'd5) begin
         errors++;
         $display("FAIL flush_req got req=%b reg=%0d want 1 5", rfReadReq_o, rfReadReg_o);
      end
      flush_i = 1'b1; flushWarp_i = 5'd4;
      tick();
      flush_i = 1'b0;
      checks++;
      if (stall_o !== 1'b1 || rfReadReq_o !== 1'b0 || exValid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_other got s=%b req=%b v=%b want 1 0 0", stall_o, rfReadReq_o, exValid_o);
      end
      flush_i = 1'b1; flushWarp_i = 5'd3;
      tick();
      flush_i = 1'b0;
      tick();
      tick();
      checks++;
      if (stall_o !== 1'b1 || rfReadReq_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_drain got s=%b req=%b want 1 0", stall_o, rfReadReq_o);
      end
      man_vld = 1'b1; man_data = 32'hDEAD_BEEF;
      tick();
      man_vld = 1'b0;
      checks++;
      if (stall_o !== 1'b0 || exOperand_o !== '0 || ex_cnt != e0) begin
         errors++;
         $display("FAIL flush_discard got s=%b op=%h ex=%0d want 0 0 0", stall_o, exOperand_o, ex_cnt - e0);
      end
      rf_en = 1'b1;
   endtask

   task automatic test_flush_dispatch();
      issue(2'd0, 5'd6, mkpkt(3'b000, 6'd0, 6'd0, 6'd0, 28'h2), 32'h1);
      flush_i = 1'b1; flushWarp_i = 5'd6;
      tick();
      flush_i = 1'b0;
      checks++;
      if (exValid_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_dispatch got v=%b s=%b want 0 0", exValid_o, stall_o);
      end
   endtask

   task automatic test_idle_flush();
      issuedWarp_i = 5'd2; issuedPacket_i = mkpkt(3'b001, 6'd4, 6'd0, 6'd0, 28'h3);
      issuedPacketValid_i = 1'b1; flush_i = 1'b1; flushWarp_i = 5'd2;
      tick();
      issuedPacketValid_i = 1'b0; flush_i = 1'b0;
      tick();
      checks++;
      if (stall_o !== 1'b0 || exValid_o !== 1'b0 || rfReadReq_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush got s=%b v=%b req=%b want 0 0 0", stall_o, exValid_o, rfReadReq_o);
      end
   endtask

   task automatic test_reset_mid_read();
      rf_en = 1'b0;
      issue(2'd3, 5'd9, mkpkt(3'b010, 6'd0, 6'd12, 6'd0, 28'h4), 32'h55);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({stall_o, rfReadReq_o, exValid_o} !== 3'b000 || rfReadReg_o !== '0 || rfReadWarp_o !== '0
          || exWarp_o !== '0 || exPacket_o !== '0 || exMask_o !== '0 || exSM_o !== '0) begin
         errors++;
         $display("FAIL reset_mid got s=%b req=%b v=%b reg=%0d w=%0d want all 0",
                  stall_o, rfReadReq_o, exValid_o, rfReadReg_o, exWarp_o);
      end
      man_vld = 1'b1; man_data = 32'h1234_5678;
      tick();
      man_vld = 1'b0;
      checks++;
      if (stall_o !== 1'b0 || exOperand_o !== '0) begin
         errors++;
         $display("FAIL reset_late_ret got s=%b op=%h want 0 0", stall_o, exOperand_o);
      end
      rf_en = 1'b1;
   endtask

   initial begin
      reset = 1'b1; issuedSM_i = '0; issuedWarp_i = '0; issuedPacketValid_i = 1'b0;
      issuedPacket_i = '0; issuedMask_i = '0; flush_i = 1'b0; flushWarp_i = '0; exReady_i = 1'b0;
      #1;
      test_reset();
      test_read();
      test_nosrc_stall();
      test_flush_read();
      test_flush_dispatch();
      test_idle_flush();
      test_reset_mid_read();
      test_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/opcol_collector.md
OPCOL_COLLECTOR -- requirements
Module: opcol_collector

Interface
REQ-001 SHALL have parameter PKT_W, default 128: issued packet width.
REQ-002 SHALL have parameter SM_W, default 2: SM id width.
REQ-003 SHALL have parameter WARP_W, default 5: warp id width.
REQ-004 SHALL have parameter CORE_N, default 32: active-mask width.
REQ-005 SHALL have parameter REG_W, default 6: register index width.
REQ-006 SHALL have parameter DATA_W, default 32: operand data width.
REQ-007 SHALL have parameter SRC_VLD_POS, default 0: packet bit of source-0 valid; sources 1 and 2 at +1 and +2.
REQ-008 SHALL have parameter SRC_REG_POS, default 3: packet LSB of source-0 index; source k at +k*REG_W.
REQ-009 SHALL have ports (clock and reset first; one clock; reset is synchronous and active-high):
 clk  in  1  clock, all logic on rising edge
 reset  in  1  synchronous active-high reset
 issuedSM_i  in  SM_W  SM id from issue pipeline register
 issuedWarp_i  in  WARP_W  warp id
 issuedPacketValid_i  in  1  packet present
 issuedPacket_i  in  PKT_W  decoded instruction packet
 issuedMask_i  in  CORE_N  thread active mask
 flush_i  in  1  flush request
 flushWarp_i  in  WARP_W  warp being flushed
 stall_o  out  1  hold issue pipeline register
 rfReadReq_o  out  1  register-file read request, one-cycle pulse
 rfReadWarp_o  out  WARP_W  read warp
 rfReadReg_o  out  REG_W  read register index
 rfReadValid_i  in  1  read data return (latency >=1 cycle, in order)
 rfReadData_i  in  DATA_W  read data
 exValid_o  out  1  collected packet to execute
 exReady_i  in  1  execute accepts
 exSM_o, exWarp_o, exPacket_o, exMask_o  out  SM_W/WARP_W/PKT_W/CORE_N  captured fields
 exOperand_o  out  3*DATA_W  operand k at [k*DATA_W +: DATA_W]

Function
REQ-010 SHALL implement states IDLE, READ, DISPATCH, DRAIN.
REQ-011 stall_o SHALL be 1 exactly when state != IDLE (registered, no combinational path from inputs).
REQ-012 In IDLE, issuedPacketValid_i=1 and not (flush_i and flushWarp_i==issuedWarp_i) SHALL capture SM, warp, packet, mask at the edge; flushed input SHALL be ignored.
REQ-013 On capture, operand registers SHALL clear to 0; next state READ if any source valid bit set, else DISPATCH.
REQ-014 In READ, with no read outstanding, SHALL pulse rfReadReq_o for the lowest-index valid source not yet read, rfReadWarp_o = captured warp, rfReadReg_o = its index; at most one request outstanding.
REQ-015 rfReadValid_i while outstanding SHALL write rfReadData_i into that source's operand slot and clear outstanding; after the last valid source returns, next state DISPATCH.
REQ-016 Invalid sources SHALL read as 0 on exOperand_o and generate no request.
REQ-017 In DISPATCH, exValid_o=1 with ex* fields stable until exValid_o & exReady_i; then next state IDLE (new packet accepted no earlier than the following cycle).
REQ-018 flush_i with flushWarp_i==captured warp in READ, or DISPATCH without exReady_i that cycle, SHALL abort: exValid_o drops next cycle; next state DRAIN if a read is outstanding, else IDLE.
REQ-019 Flush in the same cycle as exValid_o & exReady_i SHALL be ignored (handshake completes).
REQ-020 In DRAIN, SHALL discard rfReadValid_i data and go to IDLE on that return; no new requests.
REQ-021 rfReadValid_i with nothing outstanding SHALL be ignored in every state.
REQ-022 Flush of a different warp SHALL have no effect.

Reset
REQ-023 reset=1 SHALL force IDLE, clear outstanding, and drive stall_o, rfReadReq_o, exValid_o and all ex*/rf* data outputs to 0, regardless of state.
REQ-024 A read return arriving after reset SHALL be ignored.

Verification
REQ-025 Packet warp 3, sources 0 and 2 valid (regs 5, 9), RF returns 0xA, 0xB at latency 2 -> requests reg 5 then reg 9, exOperand_o = {0xB, 0, 0xA}, stall_o high from cycle after capture until cycle after handshake.
REQ-026 Packet with no valid sources -> exValid_o asserted the cycle after capture, no rfReadReq_o.
REQ-027 exReady_i low 4 cycles in DISPATCH -> exValid_o and ex* stable 4 cycles, IDLE one cycle after handshake.
REQ-028 Flush warp 3 while read outstanding -> DRAIN, returned data discarded, IDLE after return, exValid_o never asserted; flush warp 4 instead -> no effect.
REQ-029 IDLE, valid input warp 2 with flush_i warp 2 same cycle -> not captured, stall_o stays 0.
REQ-030 reset asserted in READ with read outstanding -> all outputs 0 next cycle; late rfReadValid_i ignored; next packet processed normally.
